// File: rtl/ip_codma_wr_data_stage_pkg.sv
// ip_codma_wr_data_stage_pkg: write-stage FSM states, bus size codes and beat helpers.
package ip_codma_wr_data_stage_pkg;
    typedef enum logic [1:0] {WS_IDLE, WS_REQ, WS_BEAT, WS_UNUSED} wr_stage_state_t;
    localparam logic [3:0] SIZE_2W = 4'd3;
    localparam logic [3:0] SIZE_4W = 4'd8;
    localparam logic [3:0] SIZE_8W = 4'd9;
    function automatic logic [2:0] size_to_beats(input logic [3:0] size);
        return size == SIZE_2W ? 3'd1 : size == SIZE_4W ? 3'd2 : size == SIZE_8W ? 3'd4 : 3'd0;
    endfunction
    function automatic logic size_legal(input logic [3:0] size);
        return size_to_beats(size) != 3'd0;
    endfunction
endpackage

// File: rtl/ip_codma_block_fifo.sv
// ip_codma_block_fifo: two-entry read-block store with registered pointers and count.
module ip_codma_block_fifo #(
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             clear,
    input  logic             push,
    input  logic [7:0][31:0] push_data,
    input  logic [3:0]       push_size,
    input  logic             pop,
    output logic [7:0][31:0] head_data,
    output logic [3:0]       head_size,
    output logic [1:0]       count,
    output logic             ready
);
    logic [7:0][31:0] mem_data [2];
    logic [3:0]       mem_size [2];
    logic             wr_ptr;
    logic             rd_ptr;

    assign ready     = count < 2'(DEPTH);
    assign head_data = mem_data[rd_ptr];
    assign head_size = mem_size[rd_ptr];

    // Entry contents are left unreset; only occupancy is tracked across reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_size[wr_ptr] <= push_size;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            count  <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/ip_codma_wr_data_stage.sv
// ip_codma_wr_data_stage: buffers read blocks and drives them out as 64-bit write beats.
module ip_codma_wr_data_stage
    import ip_codma_wr_data_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             load_i,
    input  logic [7:0][31:0] data_i,
    input  logic [3:0]       size_i,
    output logic             ready_o,
    input  logic             stop_i,
    input  logic             grant_i,
    input  logic             error_i,
    output logic             need_write_o,
    output logic [3:0]       size_o,
    output logic             write_valid_o,
    output logic [63:0]      write_data_o,
    output logic             block_done_o,
    output logic             size_err_o,
    output logic             overflow_o
);
    wr_stage_state_t  state;
    logic [7:0][31:0] head_data;
    logic [3:0]       head_size;
    logic [1:0]       count;
    logic [1:0]       beat;
    logic             legal;
    logic             push;
    logic             pop;
    logic             last;

    assign legal         = size_legal(size_i);
    assign push          = load_i & ready_o & legal & ~stop_i;
    assign last          = beat == 2'(size_to_beats(head_size) - 3'd1);
    assign need_write_o  = state == WS_REQ;
    assign write_valid_o = state == WS_BEAT;
    assign block_done_o  = write_valid_o & last & ~error_i & ~stop_i;
    // An errored block is discarded from either bus phase, never reported done.
    assign pop           = ~stop_i & (block_done_o | ((need_write_o | write_valid_o) & error_i));
    assign size_o        = (need_write_o | write_valid_o) ? head_size : 4'd0;
    assign write_data_o  = write_valid_o ? {head_data[{beat, 1'b1}], head_data[{beat, 1'b0}]} : 64'd0;

    ip_codma_block_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear     (stop_i),
        .push      (push),
        .push_data (data_i),
        .push_size (size_i),
        .pop       (pop),
        .head_data (head_data),
        .head_size (head_size),
        .count     (count),
        .ready     (ready_o)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= WS_IDLE;
            beat       <= 2'd0;
            size_err_o <= 1'b0;
            overflow_o <= 1'b0;
        end else if (stop_i) begin
            state      <= WS_IDLE;
            beat       <= 2'd0;
            size_err_o <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            size_err_o <= load_i & ready_o & ~legal;
            overflow_o <= overflow_o | (load_i & ~ready_o);
            case (state)
                WS_IDLE: state <= count != 2'd0 ? WS_REQ : WS_IDLE;
                WS_REQ:  state <= error_i ? WS_IDLE : grant_i ? WS_BEAT : WS_REQ;
                WS_BEAT: begin
                    state <= (error_i | last) ? WS_IDLE : WS_BEAT;
                    beat  <= (error_i | last) ? 2'd0 : beat + 2'd1;
                end
                default: begin
                    state <= WS_IDLE;
                    beat  <= 2'd0;
                end
            endcase
        end
    end
endmodule
